// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target responder.
package spi_pkg;

   // Default number of bits per SPI word.
   localparam int SPI_DATA_WIDTH = 8;

   // Word shifted out when the TX holding register is empty at word start.
   localparam logic [SPI_DATA_WIDTH-1:0] SPI_TX_IDLE = 8'hFF;

   // Frame sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE,
      ST_WAIT
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one SPI pin, with optional rise/fall detect.
// Edges compare the last synchroniser stage with one extra registered copy,
// so an edge is acted upon SYNC_STAGES+1 CLK after it reaches the pin.
module spi_input_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0,
   parameter bit   EDGE_DETECT = 1'b1
) (
   input  logic CLK,
   input  logic reset_in,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw pin through the synchroniser chain.
   always_ff @(posedge CLK or posedge reset_in) begin
      // NOTE: state is written with <= so every flop samples pre-edge values;
      // blocking here would collapse the chain into a single stage.
      if (reset_in) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

   if (EDGE_DETECT) begin : g_edge
      logic prev_q;

      // Delayed copy of the synchronised level for edge detection.
      always_ff @(posedge CLK or posedge reset_in) begin
         if (reset_in) prev_q <= RESET_VAL;
         else          prev_q <= sync_o;
      end

      assign rise_o =  sync_o & ~prev_q;
      assign fall_o = ~sync_o &  prev_q;
   end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
   end

endmodule : spi_input_sync

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target, MSB first. SCLK/SS/MOSI are oversampled in the CLK
// domain (f_CLK >= 8*f_sclk); one-entry TX and RX buffers with valid/ready.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] TX_IDLE     = DATA_WIDTH'(SPI_TX_IDLE)
) (
   input  logic                  CLK,
   input  logic                  reset_in,
   input  logic                  spi_sclk,
   input  logic                  spi_ss_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  rx_overrun,
   output logic                  frame_abort
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic sclk_rise, sclk_fall;
   logic ss_rise, ss_fall;
   logic mosi_sync;
   logic ss_sync, sclk_sync;
   // mosi is sampled on sclk edges; its own edges are not needed.
   logic [1:0] unused_mosi_edges;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sync_sclk (
      .CLK(CLK), .reset_in(reset_in), .pin_i(spi_sclk),
      .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_DETECT(1'b1)) u_sync_ss (
      .CLK(CLK), .reset_in(reset_in), .pin_i(spi_ss_n),
      .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_sync_mosi (
      .CLK(CLK), .reset_in(reset_in), .pin_i(spi_mosi),
      .sync_o(mosi_sync), .rise_o(unused_mosi_edges[0]), .fall_o(unused_mosi_edges[1])
   );

   spi_state_e            state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
   logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
   logic                  miso_q, miso_d;
   logic                  miso_oe_q, miso_oe_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   logic                  overrun_q, overrun_d;
   logic                  abort_q, abort_d;
   logic                  deliver;
   logic [DATA_WIDTH-1:0] load_word;

   // State and datapath registers; every flop returns to its idle value on reset.
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_tx_q  <= '0;
         shift_rx_q  <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_tx_q  <= shift_tx_d;
         shift_rx_q  <= shift_rx_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
         abort_q     <= abort_d;
      end
   end

   // Frame sequencer plus TX/RX buffer next-state logic.
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_tx_d  = shift_tx_q;
      shift_rx_d  = shift_rx_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      abort_d     = 1'b0;
      deliver     = 1'b0;
      load_word   = hold_full_q ? hold_q : TX_IDLE;

      case (state_q)
         ST_IDLE: begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            bit_cnt_d = '0;
            if (ss_fall) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (ss_rise) begin
               state_d   = ST_IDLE;
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
            end else begin
               // Uses the pre-cycle holding state: a write landing this
               // cycle stays in the holding register for the next word.
               if (hold_full_q) hold_full_d = 1'b0;
               else             underrun_d  = 1'b1;
               shift_tx_d = load_word;
               miso_d     = load_word[DATA_WIDTH-1];
               miso_oe_d  = 1'b1;
               bit_cnt_d  = '0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               // SS release wins over any sclk edge in the same cycle.
               state_d   = ST_IDLE;
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
               bit_cnt_d = '0;
               abort_d   = (bit_cnt_q != '0);
            end else if (sclk_rise) begin
               shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_sync};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_LAST) state_d = ST_DONE;
            end else if (sclk_fall && bit_cnt_q != '0) begin
               shift_tx_d = shift_tx_q << 1;
               miso_d     = shift_tx_q[DATA_WIDTH-2];
            end
         end
         ST_DONE: begin
            deliver   = 1'b1;
            bit_cnt_d = '0;
            if (ss_rise) begin
               state_d   = ST_IDLE;
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ss_rise) begin
               state_d   = ST_IDLE;
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
            end else if (sclk_fall) begin
               // The last falling edge of a word doubles as the first
               // shift edge of a back-to-back word.
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            bit_cnt_d = '0;
         end
      endcase

      // TX holding register: a write is only taken while empty, and a
      // LOAD can only empty it when it was already full, so they never clash.
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      // RX buffer: a completed word replaces the buffered one only if it
      // is being consumed in the same cycle; otherwise it is dropped.
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_rx_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q != ST_IDLE);
   assign tx_underrun = underrun_q;
   assign rx_overrun  = overrun_q;
   assign frame_abort = abort_q;

endmodule : spi_slave_responder

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as an SPI mode-0 initiator
// with sclk = CLK/8 (4 CLK low, 4 CLK high).
module tb_spi_slave_responder;

   logic       CLK = 1'b0;
   logic       reset_in;
   logic       spi_sclk, spi_ss_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       busy, tx_underrun, rx_overrun, frame_abort;

   spi_slave_responder dut (
      .CLK(CLK), .reset_in(reset_in),
      .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun),
      .frame_abort(frame_abort)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse and RX-acceptance monitor, sampled on the inactive edge.
   int         underrun_cnt = 0, overrun_cnt = 0, abort_cnt = 0, rx_cnt = 0;
   logic [7:0] rx_log [0:63];

   always @(negedge CLK) begin
      if (tx_underrun) underrun_cnt++;
      if (rx_overrun)  overrun_cnt++;
      if (frame_abort) abort_cnt++;
      if (rx_valid && rx_ready && rx_cnt < 64) begin
         rx_log[rx_cnt] = rx_data;
         rx_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic tx_write(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic frame_begin(input string tag);
      spi_ss_n = 1'b0;
      tick(8);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_oe"},   32'(spi_miso_oe), 32'd1);
   endtask

   // Shift nbits MSB first; on the final bit with end_frame, SS rises together
   // with the last sclk fall.
   task automatic shift_bits(input logic [7:0] mo, input int nbits, input bit end_frame,
                             output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         tick(4);
         mi = {mi[6:0], spi_miso};
         spi_sclk = 1'b1;
         tick(4);
         spi_sclk = 1'b0;
         if (end_frame && i == nbits - 1) spi_ss_n = 1'b1;
      end
      if (end_frame) begin
         spi_mosi = 1'b0;
         tick(10);
      end
   endtask

   logic [7:0] m1, m2;
   int         u0, o0, a0, r0;

   initial begin
      reset_in = 1'b1;
      spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
      tx_data  = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      tick(3);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data",  32'(rx_data),  32'd0);
      check("rst_oe_miso",  {30'd0, spi_miso_oe, spi_miso}, 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_pulses",   {29'd0, tx_underrun, rx_overrun, frame_abort}, 32'd0);
      reset_in = 1'b0;
      tick(4);

      // Single word: 0xA5 out, 0x3C in.
      u0 = underrun_cnt;
      tx_write(8'hA5);
      check("single_tx_full", 32'(tx_ready), 32'd0);
      frame_begin("single");
      check("single_tx_ready_after_load", 32'(tx_ready), 32'd1);
      shift_bits(8'h3C, 8, 1'b1, m1);
      check("single_miso",     32'(m1), 32'hA5);
      check("single_rx_valid", 32'(rx_valid), 32'd1);
      check("single_rx_data",  32'(rx_data), 32'h3C);
      check("single_underrun", 32'(underrun_cnt - u0), 32'd0);
      check("single_idle",     {30'd0, busy, spi_miso_oe}, 32'd0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("single_rx_drained", 32'(rx_valid), 32'd0);

      // Back-to-back: 0x12,0x34 out; 0x81,0x7E in; consumer always ready.
      u0 = underrun_cnt; r0 = rx_cnt;
      rx_ready = 1'b1;
      tx_write(8'h12);
      frame_begin("b2b");
      tx_write(8'h34);
      shift_bits(8'h81, 8, 1'b0, m1);
      shift_bits(8'h7E, 8, 1'b1, m2);
      check("b2b_miso0",    32'(m1), 32'h12);
      check("b2b_miso1",    32'(m2), 32'h34);
      check("b2b_rx_count", 32'(rx_cnt - r0), 32'd2);
      check("b2b_rx0",      32'(rx_log[r0]),     32'h81);
      check("b2b_rx1",      32'(rx_log[r0 + 1]), 32'h7E);
      check("b2b_underrun", 32'(underrun_cnt - u0), 32'd0);
      check("b2b_tx_ready", 32'(tx_ready), 32'd1);

      // Underrun: nothing queued, idle word shifted out.
      u0 = underrun_cnt; r0 = rx_cnt;
      frame_begin("under");
      shift_bits(8'hC3, 8, 1'b1, m1);
      check("under_miso",     32'(m1), 32'hFF);
      check("under_pulses",   32'(underrun_cnt - u0), 32'd1);
      check("under_rx_count", 32'(rx_cnt - r0), 32'd1);
      check("under_rx_data",  32'(rx_log[r0]), 32'hC3);
      rx_ready = 1'b0;
      tick(2);

      // Overrun: consumer stalled across two words.
      o0 = overrun_cnt;
      frame_begin("over");
      shift_bits(8'h11, 8, 1'b0, m1);
      shift_bits(8'h22, 8, 1'b1, m2);
      check("over_rx_valid", 32'(rx_valid), 32'd1);
      check("over_rx_data",  32'(rx_data), 32'h11);
      check("over_pulses",   32'(overrun_cnt - o0), 32'd1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("over_drained", 32'(rx_valid), 32'd0);

      // Abort after 5 bits, then a clean frame must realign.
      a0 = abort_cnt;
      frame_begin("abort");
      shift_bits(8'hF0, 5, 1'b1, m1);
      check("abort_pulses",   32'(abort_cnt - a0), 32'd1);
      check("abort_rx_valid", 32'(rx_valid), 32'd0);
      check("abort_busy",     32'(busy), 32'd0);
      tx_write(8'h96);
      frame_begin("realign");
      shift_bits(8'h5A, 8, 1'b1, m1);
      check("realign_miso",    32'(m1), 32'h96);
      check("realign_rx_data", 32'(rx_data), 32'h5A);
      check("realign_abort",   32'(abort_cnt - a0), 32'd1);

      // Asynchronous reset in the middle of a frame (rx_valid still set).
      tx_write(8'h55);
      frame_begin("midrst");
      tx_write(8'h77);
      shift_bits(8'h0F, 3, 1'b0, m1);
      check("midrst_pre_tx_ready", 32'(tx_ready), 32'd0);
      reset_in = 1'b1;
      #1;
      check("midrst_tx_ready", 32'(tx_ready), 32'd1);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      check("midrst_oe_miso",  {30'd0, spi_miso_oe, spi_miso}, 32'd0);
      check("midrst_busy",     32'(busy), 32'd0);
      tick(2);
      spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
      tick(2);
      reset_in = 1'b0;
      tick(4);
      tx_write(8'hE7);
      frame_begin("postrst");
      shift_bits(8'h99, 8, 1'b1, m1);
      check("postrst_miso",    32'(m1), 32'hE7);
      check("postrst_rx_data", 32'(rx_data), 32'h99);
      check("postrst_rx_valid", 32'(rx_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_spi_slave_responder
